// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//   Serial-in/parallel-out receiver. Assembles WIDTH-bit words from a one-bit
//   stream in either MSB-first or LSB-first framing. Each completed word is
//   presented on a registered output with a valid/ready handshake.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   shift_input  : serial data bit
//   bit_valid    : shift_input is sampled on this edge when 1
//   msb_first    : framing order for the next word (1 = MSB first)
//   clear        : synchronous flush of partial word, out_valid and overrun
//   data_out     : last completed word
//   out_valid    : data_out holds an unconsumed word
//   out_ready    : consumer accepts data_out when out_valid & out_ready
//   overrun      : sticky, a completed word was dropped
//   bit_count    : bits collected in the current word
module serial_to_parallel_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_input,
  input  logic                     bit_valid,
  input  logic                     msb_first,
  input  logic                     clear,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             order_q, order_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             order_now;
  logic [WIDTH-1:0] shifted;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      order_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state     = (cnt_q == '0) ? IDLE : COLLECT;
    // The first bit of a word uses the live pin; later bits use the latched order.
    order_now = (state == IDLE) ? msb_first : order_q;
    shifted   = order_now ? {sr_q[WIDTH-2:0], shift_input}
                          : {shift_input, sr_q[WIDTH-1:1]};

    sr_d    = sr_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (clear) begin
      sr_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      if (bit_valid) begin
        sr_d = shifted;
        if (state == IDLE) begin
          order_d = msb_first;
        end
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // Slot is free if empty or being consumed on this same edge.
          if (!valid_q || out_ready) begin
            data_d  = shifted;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Outputs, straight from registers
  always_comb begin
    data_out  = data_q;
    out_valid = valid_q;
    overrun   = ovr_q;
    bit_count = cnt_q;
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx
//   Bench for serial_to_parallel_rx: directed scenarios plus a randomized
//   phase, all checked against a word-level reference model.
module tb_serial_to_parallel_rx;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  logic          clk;
  logic          rst_n;
  logic          si, bv, msb, clr, rdy;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic          overrun;
  logic [CW-1:0] bit_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: collected bits of the current word and the output slot.
  int unsigned  m_n;
  logic         m_bits [W];
  logic         m_order;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;

  serial_to_parallel_rx #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_input (si),
    .bit_valid   (bv),
    .msb_first   (msb),
    .clear       (clr),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (rdy),
    .overrun     (overrun),
    .bit_count   (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n     = 0;
    m_order = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Word value from the bit arrival order: first bit lands at the top for
  // MSB-first framing, at bit 0 for LSB-first framing.
  function automatic logic [W-1:0] assemble(input logic order);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (order) w[W-1-i] = m_bits[i];
      else       w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_edge();
    logic old_valid;
    logic [W-1:0] w;
    old_valid = m_valid;
    if (clr) begin
      m_n     = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (old_valid && rdy) m_valid = 1'b0;
      if (bv) begin
        if (m_n == 0) m_order = msb;
        m_bits[m_n] = si;
        m_n++;
        if (m_n == W) begin
          w   = assemble(m_order);
          m_n = 0;
          if (!old_valid || rdy) begin
            m_data  = w;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".data"},  32'(data_out),  32'(m_data));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
    chk({tag, ".cnt"},   32'(bit_count), 32'(m_n));
  endtask

  // One clock: model follows the inputs present at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    si = 1'b0; bv = 1'b0; clr = 1'b0; rdy = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.data",  32'(data_out),  32'h0);
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.ovr",   32'(overrun),   32'h0);
    chk("rst.cnt",   32'(bit_count), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  // Send nbits of word in framing order 'order'; msb_first pin flips from
  // bit 'toggle_at' onward. out_ready is 'rdy_body' except on the final bit.
  task automatic send_bits(input logic [W-1:0] word, input logic order, input int nbits,
                           input int toggle_at, input logic rdy_body, input logic rdy_last,
                           input string tag);
    for (int i = 0; i < nbits; i++) begin
      bv  = 1'b1;
      si  = order ? word[W-1-i] : word[i];
      msb = (i >= toggle_at) ? ~order : order;
      rdy = (i == int'(W) - 1) ? rdy_last : rdy_body;
      step(tag);
    end
    bv  = 1'b0;
    rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    msb   = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("reset.data",  32'(data_out),  32'h0);
    chk("reset.valid", 32'(out_valid), 32'h0);
    chk("reset.ovr",   32'(overrun),   32'h0);
    chk("reset.cnt",   32'(bit_count), 32'h0);
    #7;
    rst_n = 1'b1;
    step("idle");

    // MSB-first and LSB-first framing of the same byte
    send_bits(8'hB2, 1'b1, W, W, 1'b0, 1'b0, "msb");
    chk("msb.B2", 32'(data_out), 32'hB2);
    chk("msb.vld", 32'(out_valid), 32'h1);
    chk("msb.cnt0", 32'(bit_count), 32'h0);
    rdy = 1'b1; step("consume"); rdy = 1'b0;
    send_bits(8'hB2, 1'b0, W, W, 1'b0, 1'b0, "lsb");
    chk("lsb.B2", 32'(data_out), 32'hB2);
    rdy = 1'b1; step("consume"); rdy = 1'b0;
    send_bits(8'hB2, 1'b0, W, 4, 1'b0, 1'b0, "lsbtog");
    chk("lsbtog.B2", 32'(data_out), 32'hB2);
    rdy = 1'b1; step("consume"); rdy = 1'b0;

    // Gapped MSB-first 5A
    for (int i = 0; i < int'(W); i++) begin
      logic [W-1:0] w;
      logic [CW-1:0] held;
      w = 8'h5A;
      bv = 1'b1; si = w[W-1-i]; msb = 1'b1;
      step("gap.bit");
      held = bit_count;
      bv = 1'b0; si = ~si; msb = 1'b0;
      step("gap.idle");
      chk("gap.hold", 32'(bit_count), 32'(held));
    end
    chk("gap.5A", 32'(data_out), 32'h5A);

    // Overrun, then simultaneous consume and completion
    clr = 1'b1; step("clr"); clr = 1'b0;
    send_bits(8'h11, 1'b1, W, W, 1'b0, 1'b0, "ovr1");
    send_bits(8'h22, 1'b1, W, W, 1'b0, 1'b0, "ovr2");
    chk("ovr.data", 32'(data_out), 32'h11);
    chk("ovr.flag", 32'(overrun), 32'h1);
    rdy = 1'b1; step("ovr.sticky"); rdy = 1'b0;
    chk("ovr.sticky", 32'(overrun), 32'h1);
    clr = 1'b1; step("clr"); clr = 1'b0;
    send_bits(8'h11, 1'b1, W, W, 1'b0, 1'b0, "sim1");
    send_bits(8'h22, 1'b1, W, W, 1'b0, 1'b1, "sim2");
    chk("sim.data", 32'(data_out), 32'h22);
    chk("sim.vld",  32'(out_valid), 32'h1);
    chk("sim.ovr",  32'(overrun), 32'h0);

    // Reset and clear mid-word
    send_bits(8'hFF, 1'b1, 5, W, 1'b0, 1'b0, "part");
    pulse_reset();
    send_bits(8'hC3, 1'b1, W, W, 1'b0, 1'b0, "c3a");
    chk("c3a", 32'(data_out), 32'hC3);
    rdy = 1'b1; step("consume"); rdy = 1'b0;
    send_bits(8'h0F, 1'b0, 5, W, 1'b0, 1'b0, "part2");
    clr = 1'b1; step("midclr"); clr = 1'b0;
    chk("clr.cnt",  32'(bit_count), 32'h0);
    chk("clr.data", 32'(data_out), 32'hC3);
    send_bits(8'hC3, 1'b0, W, W, 1'b0, 1'b0, "c3b");
    chk("c3b", 32'(data_out), 32'hC3);

    // Streaming with out_ready held high
    rdy = 1'b1; step("drain");
    foreach (m_bits[k]) m_bits[k] = m_bits[k];
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] sw;
      case (k)
        0: sw = 8'h01;
        1: sw = 8'h80;
        2: sw = 8'hFF;
        default: sw = 8'h00;
      endcase
      send_bits(sw, 1'b1, W, W, 1'b1, 1'b1, "stream");
      chk("stream.word", 32'(data_out), 32'(sw));
      chk("stream.vld",  32'(out_valid), 32'h1);
      chk("stream.ovr",  32'(overrun), 32'h0);
      rdy = 1'b1;
    end
    rdy = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bv  = ($urandom_range(0, 9) < 7);
      si  = 1'($urandom);
      msb = 1'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) begin
        idle_inputs();
        pulse_reset();
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Serial-in/parallel-out receiver for the 8-bit shift-register datapath. It takes the one-bit serial stream produced by the shift register's `shift_output` and reassembles it into bytes. Each completed byte is presented on a registered parallel output with a valid/ready handshake. The block sits at the far end of the serial link and feeds the next parallel consumer.

## Interface
Parameters:
- `WIDTH`, default 8: word length in bits. Must be at least 2.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `shift_input` input 1: serial data bit.
- `bit_valid` input 1: `shift_input` is sampled on an edge only when this is 1.
- `msb_first` input 1: bit order. 1 = MSB first (left-shift framing), 0 = LSB first (right-shift framing).
- `clear` input 1: synchronous flush of any partial word and flags.
- `data_out` output WIDTH: last completed word.
- `out_valid` output 1: `data_out` holds an unconsumed word.
- `out_ready` input 1: consumer accepts `data_out` when `out_valid & out_ready`.
- `overrun` output 1: sticky flag; a completed word was dropped.
- `bit_count` output $clog2(WIDTH): number of bits collected in the current word.

## Operation
- Registers: shift register `sr[WIDTH-1:0]`, `bit_count`, latched order bit `order_q`, `data_out`, `out_valid`, `overrun`.
- Reset (`rst_n`=0, takes effect immediately, no clock needed): every register clears to 0. This covers `data_out`=0, `out_valid`=0, `overrun`=0 and `bit_count`=0.
- States (implicit in `bit_count`):
  - IDLE: `bit_count`=0.
  - COLLECT: 1 ≤ `bit_count` ≤ WIDTH-1.
- Bit accept (`bit_valid`=1, `clear`=0):
  - If `bit_count`=0, `order_q` latches `msb_first`. The order used for this first bit is `msb_first` itself.
  - For later bits the order is `order_q`. Changing `msb_first` mid-word has no effect until the next word.
  - MSB first: `sr` becomes `{sr[WIDTH-2:0], shift_input}`.
  - LSB first: `sr` becomes `{shift_input, sr[WIDTH-1:1]}`.
  - `bit_count` increments by 1.
- Word completion (bit accepted while `bit_count`=WIDTH-1):
  - The assembled word is the post-shift value defined above.
  - `bit_count` wraps to 0.
  - If the output slot is free (`out_valid`=0, or `out_valid`=1 and `out_ready`=1 on this edge), `data_out` takes the new word and `out_valid`=1.
  - Otherwise (`out_valid`=1, `out_ready`=0) the new word is discarded, `data_out` is unchanged and `overrun` is set to 1.
- Consume: on `out_valid & out_ready` with no completion on the same edge, `out_valid` goes to 0. `data_out` keeps its value.
- `clear`=1 has priority over every other input. On that edge: `sr`=0, `bit_count`=0, `out_valid`=0, `overrun`=0. `data_out` is unchanged.
- `overrun` is cleared only by `clear` or reset. A later consume does not clear it.
- `bit_valid`=0: `sr`, `bit_count` and `order_q` hold. A handshake may still complete.

## Timing
- Latency: the edge that samples the final bit is the same edge that updates `data_out` and sets `out_valid`. Both are visible immediately after that edge.
- Throughput: one bit per clock. With `bit_valid` high continuously, a word completes every WIDTH cycles.
- Back-to-back words need no gap. Bit 0 of the next word may be accepted on the cycle after completion.
- Simultaneous completion and consume on one edge: the old word is consumed and the new word is loaded. `out_valid` stays 1 and `overrun` is not set.
- `out_ready` while `out_valid`=0 has no effect.
- Reset asserted mid-word: the partial word is lost and the outputs clear at once. After `rst_n` deasserts, the first accepted bit is bit 0 of a new word.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- MSB-first byte: `msb_first`=1, serial bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, `out_ready`=0.
  - After the 8th edge: `data_out`=8'hB2, `out_valid`=1, `bit_count`=0.
- LSB-first byte: `msb_first`=0, serial bits 0,1,0,0,1,1,0,1.
  - Result: `data_out`=8'hB2.
  - Toggle `msb_first` after bit 3: the result is still 8'hB2.
- Gapped input: send 8'h5A MSB-first with `bit_valid` low on alternating cycles.
  - `data_out`=8'h5A after the 8th accepted bit.
  - `bit_count` holds its value on every gap cycle.
- Overrun: complete 8'h11, hold `out_ready`=0, then complete 8'h22.
  - `data_out` stays 8'h11 and `overrun`=1.
  - Repeat with `out_ready`=1 on the completion edge of 8'h22: `data_out`=8'h22, `out_valid`=1, `overrun`=0.
- Reset and clear mid-word:
  - Pulse `rst_n` low after 5 bits: all outputs are 0 immediately.
  - Repeat using `clear` after 5 bits: `bit_count` is 0 and `data_out` is unchanged.
  - In both cases a fresh 8'hC3 then assembles correctly.
- Streaming: 4 words (8'h01, 8'h80, 8'hFF, 8'h00) with `bit_valid` held high and `out_ready`=1.
  - `out_valid` pulses for 1 cycle every 8 cycles, carrying the words in order.
  - `overrun` stays 0 throughout.
